// File: rtl/led_count_game_if.sv
// led_count_game_if: mode-enable, button and display bundle of the LED-count game
interface led_count_game_if #(
    parameter int NUM_LEDS = 16
);
    logic                active;
    logic                btn_go_stop;
    logic [NUM_LEDS-1:0] led;
    logic [19:0]         seg_data;
    logic                win;
    logic                lose;
    logic [3:0]          tries_left;

    modport master (
        output active, btn_go_stop,
        input  led, seg_data, win, lose, tries_left
    );

    modport slave (
        input  active, btn_go_stop,
        output led, seg_data, win, lose, tries_left
    );
endinterface

// File: rtl/led_count_game.sv
// led_count_game: freeze a ping-pong LED bar on a random target count within a try limit
module led_count_game #(
    parameter int NUM_LEDS    = 16,
    parameter int TICK_CYCLES = 100_000_000,
    parameter int MAX_TRIES   = 8
) (
    input logic              clk,
    input logic              reset_n,
    led_count_game_if.slave  bus
);
    localparam int CW = $clog2(NUM_LEDS + 1);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [4:0] G_U = 5'd15, G_P = 5'd16, G_O = 5'd17, G_D = 5'd19, G_N = 5'd20;
    localparam logic [4:0] G_L = 5'd21, G_S = 5'd5, G_E = 5'd14, G_G = 5'd9, G_B = 5'd31;
    localparam logic [19:0] SEG_BLANK = 20'hFFFFF;
    localparam logic [19:0] SEG_GOOD  = {G_G, G_O, G_O, G_D};
    localparam logic [19:0] SEG_LOSE  = {G_L, G_O, G_S, G_E};

    typedef enum logic [2:0] {IDLE, RUN, HOLD, WIN, LOSE} state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [CW-1:0] bar, target, cand, next_bar;
    logic [TW-1:0] cnt;
    logic          up, next_up, btn_prev, press, tick;

    function automatic logic [NUM_LEDS-1:0] bar_mask(input logic [CW-1:0] n);
        for (int i = 0; i < NUM_LEDS; i++) bar_mask[i] = i < int'(n);
    endfunction

    function automatic logic [9:0] dec(input logic [CW-1:0] v);
        logic [5:0] w;
        logic [4:0] t;
        w = 6'(v);
        t = w >= 6'd30 ? 5'd3 : w >= 6'd20 ? 5'd2 : w >= 6'd10 ? 5'd1 : 5'd0;
        dec = {t, 5'(w - 6'(t) * 6'd10)};
    endfunction

    assign cand     = lfsr[CW-1:0];
    assign press    = bus.btn_go_stop & ~btn_prev;
    assign tick     = cnt == TW'(TICK_CYCLES - 1);
    assign next_bar = up ? (bar == CW'(NUM_LEDS) ? bar - CW'(1) : bar + CW'(1))
                         : (bar == CW'(1) ? bar + CW'(1) : bar - CW'(1));
    assign next_up  = up ? bar != CW'(NUM_LEDS) : bar == CW'(1);

    // game state machine with registered LED, display and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            lfsr           <= 16'hACE1;
            btn_prev       <= 1'b0;
            bar            <= '0;
            target         <= '0;
            up             <= 1'b1;
            cnt            <= '0;
            bus.led        <= '0;
            bus.seg_data   <= SEG_BLANK;
            bus.win        <= 1'b0;
            bus.lose       <= 1'b0;
            bus.tries_left <= 4'(MAX_TRIES);
        end else begin
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
            btn_prev <= bus.btn_go_stop;
            if (!bus.active) begin
                state          <= IDLE;
                bar            <= '0;
                up             <= 1'b1;
                cnt            <= '0;
                bus.led        <= '0;
                bus.seg_data   <= SEG_BLANK;
                bus.win        <= 1'b0;
                bus.lose       <= 1'b0;
                bus.tries_left <= 4'(MAX_TRIES);
            end else begin
                case (state)
                    IDLE: if (cand != '0 && cand <= CW'(NUM_LEDS)) begin
                        target       <= cand;
                        state        <= RUN;
                        cnt          <= '0;
                        bus.seg_data <= {G_B, G_B, dec(cand)};
                    end
                    RUN: if (press) begin
                        if (bar == target) begin
                            state        <= WIN;
                            bus.win      <= 1'b1;
                            bus.seg_data <= SEG_GOOD;
                        end else if (bus.tries_left == 4'd1) begin
                            state          <= LOSE;
                            bus.lose       <= 1'b1;
                            bus.led        <= '0;
                            bus.tries_left <= 4'd0;
                            bus.seg_data   <= SEG_LOSE;
                        end else begin
                            state          <= HOLD;
                            bus.tries_left <= bus.tries_left - 4'd1;
                            bus.seg_data   <= {dec(bar), bar < target ? {G_U, G_P} : {G_D, G_N}};
                        end
                    end else if (tick) begin
                        cnt     <= '0;
                        bar     <= next_bar;
                        up      <= next_up;
                        bus.led <= bar_mask(next_bar);
                    end else begin
                        cnt <= cnt + TW'(1);
                    end
                    HOLD: if (press) begin
                        state        <= RUN;
                        cnt          <= '0;
                        bus.seg_data <= {G_B, G_B, dec(target)};
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_count_game.sv
// tb_led_count_game: random and directed play against a rule-level game model
module tb_led_count_game;
    localparam int N  = 5;
    localparam int TC = 4;
    localparam int MT = 3;
    localparam int CW = $clog2(N + 1);
    localparam int P_IDLE = 0, P_RUN = 1, P_HOLD = 2, P_WIN = 3, P_LOSE = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int m_lfsr, m_phase, m_k, m_cyc, m_target, m_tries, m_bp;

    led_count_game_if #(.NUM_LEDS(N)) bus();

    led_count_game #(.NUM_LEDS(N), .TICK_CYCLES(TC), .MAX_TRIES(MT)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // free-running clock
    always #5 clk = ~clk;

    // hard stop if something never terminates
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bar height after k steps of a 1..N..1 triangle wave starting from zero
    function automatic int pingpong(input int k);
        int r;
        if (k == 0) return 0;
        r = (k - 1) % (2 * (N - 1));
        return r < N ? r + 1 : 2 * N - 1 - r;
    endfunction

    function automatic int glyphs(input int v);
        return ((v / 10) << 5) | (v % 10);
    endfunction

    function automatic logic [31:0] exp_seg();
        int b;
        b = pingpong(m_k);
        case (m_phase)
            P_RUN:   return (31 << 15) | (31 << 10) | glyphs(m_target);
            P_HOLD:  return (glyphs(b) << 10) | (b < m_target ? (15 << 5) | 16 : (19 << 5) | 20);
            P_WIN:   return (9 << 15) | (17 << 10) | (17 << 5) | 19;
            P_LOSE:  return (21 << 15) | (17 << 10) | (5 << 5) | 14;
            default: return 32'hFFFFF;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr   = 'hACE1;
        m_phase  = P_IDLE;
        m_k      = 0;
        m_cyc    = 0;
        m_target = 0;
        m_tries  = MT;
        m_bp     = 0;
    endtask

    task automatic model_step(input int a, input int b);
        int cand, fb, cur;
        bit edge_seen;
        edge_seen = b != 0 && m_bp == 0;
        m_bp = b;
        cand = m_lfsr % (1 << CW);
        fb = ((m_lfsr >> 15) ^ (m_lfsr >> 14) ^ (m_lfsr >> 12) ^ (m_lfsr >> 3)) & 1;
        m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
        cur = pingpong(m_k);
        if (a == 0) begin
            m_phase = P_IDLE;
            m_k = 0;
            m_cyc = 0;
            m_tries = MT;
        end else if (m_phase == P_IDLE) begin
            if (cand >= 1 && cand <= N) begin
                m_target = cand;
                m_phase = P_RUN;
                m_cyc = 0;
            end
        end else if (m_phase == P_RUN) begin
            if (edge_seen) begin
                if (cur == m_target) m_phase = P_WIN;
                else if (m_tries == 1) begin
                    m_tries = 0;
                    m_phase = P_LOSE;
                end else begin
                    m_tries--;
                    m_phase = P_HOLD;
                end
            end else begin
                m_cyc++;
                if (m_cyc == TC) begin
                    m_cyc = 0;
                    m_k++;
                end
            end
        end else if (m_phase == P_HOLD && edge_seen) begin
            m_phase = P_RUN;
            m_cyc = 0;
        end
    endtask

    task automatic check_outputs();
        check("led", 32'(bus.led), m_phase == P_LOSE ? 0 : (1 << pingpong(m_k)) - 1);
        check("seg_data", 32'(bus.seg_data), exp_seg());
        check("win", 32'(bus.win), 32'(m_phase == P_WIN));
        check("lose", 32'(bus.lose), 32'(m_phase == P_LOSE));
        check("tries_left", 32'(bus.tries_left), m_tries);
    endtask

    task automatic cycle(input int a, input int b);
        @(negedge clk);
        bus.active = a[0];
        bus.btn_go_stop = b[0];
        @(posedge clk);
        model_step(a, b);
        #1;
        check_outputs();
    endtask

    task automatic press_at(input int x, input bit on_tick);
        int n = 0;
        while (!(m_phase == P_RUN && pingpong(m_k) == x && (!on_tick || m_cyc == TC - 1)) && n < 400) begin
            cycle(1, 0);
            n++;
        end
        check("wait_for_bar", 32'(n < 400), 1);
        cycle(1, 1);
        cycle(1, 0);
    endtask

    task automatic resume();
        cycle(1, 1);
        cycle(1, 0);
    endtask

    task automatic enter_run();
        int n = 0;
        while (m_phase != P_RUN && n < 200) begin
            cycle(1, 0);
            n++;
        end
        check("enter_run", 32'(m_phase == P_RUN), 1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // directed scenarios followed by randomized play
    initial begin
        bus.active = 1'b0;
        bus.btn_go_stop = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        reset_n = 1'b1;
        repeat (4) cycle(0, 0);
        repeat (45) cycle(1, 0);
        press_at(m_target > 1 ? m_target - 1 : m_target + 1, 1'b0);
        resume();
        press_at(m_target < N ? m_target + 1 : m_target - 1, 1'b0);
        resume();
        press_at(m_target, 1'b0);
        repeat (4) resume();
        cycle(0, 0);
        enter_run();
        press_at(3, 1'b1);
        cycle(0, 0);
        cycle(0, 0);
        enter_run();
        repeat (3) begin
            if (m_phase == P_HOLD) resume();
            press_at(m_target > 1 ? m_target - 1 : m_target + 1, 1'b0);
        end
        repeat (4) resume();
        cycle(0, 0);
        enter_run();
        repeat (10) cycle(1, 0);
        async_reset();
        repeat (3000) begin
            if ($urandom_range(0, 499) == 0) async_reset();
            cycle(int'($urandom_range(0, 59) != 0), int'($urandom_range(0, 5) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_count_game.md
# led_count_game

Parametrised LED-count guessing mode for the board's mode selector. A bar of lit LEDs grows and shrinks once per tick, and the player presses GO/STOP to freeze it on a random target count. Each miss shows an UP/dn hint and uses one try. The block adds a configurable LED count, tick period and try limit, plus a LOSE outcome when the tries run out. It drives the LED bank and the 4-digit 7-segment data bus consumed by the shared segment driver.

## Interface
- NUM_LEDS, 16, LEDs in the bar; legal range 2..32.
- TICK_CYCLES, 100_000_000, clk cycles per bar step; must be ≥2.
- MAX_TRIES, 8, misses allowed before LOSE; legal range 1..15.
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- active  in  1  mode enable; low holds the block in IDLE.
- btn_go_stop  in  1  debounced button level; the block detects rising edges internally.
- led  out  NUM_LEDS  bar display; bit 0 is the first LED lit.
- seg_data  out  20  four 5-bit glyph codes; [19:15] is the leftmost digit.
- win  out  1  high in WIN.
- lose  out  1  high in LOSE.
- tries_left  out  4  remaining tries.

## Operation
- Glyph codes: 0–9 are digits; U=15, P=16, o=17, d=19, n=20, L=21, S=5, E=14, g=9, blank=31.
- LFSR: 16-bit, taps 16/15/13/4, value 16'hACE1 after reset, and it advances every clk in all states.
- States are IDLE, RUN, HOLD, WIN and LOSE.
- **IDLE** (entered whenever active=0):
  - led=0, seg_data all blank, bar=0, tries_left=MAX_TRIES.
  - When active=1, the candidate is the low clog2(NUM_LEDS+1) bits of the LFSR.
  - If the candidate is in 1..NUM_LEDS it becomes target and the state moves to RUN. Otherwise the block retries on the next cycle.
- **RUN**:
  - bar ping-pongs: 1,2,…,NUM_LEDS,NUM_LEDS−1,…,1,2,…; it steps once per tick. The first tick after IDLE sets bar=1.
  - led = bar ones in the low bits.
  - seg_data = {blank, blank, target tens, target ones}.
  - A rising edge of btn_go_stop freezes bar and triggers judging in that cycle:
    - bar==target → WIN.
    - bar≠target and tries_left==1 → tries_left=0, then LOSE.
    - otherwise tries_left decrements and the state moves to HOLD.
- **HOLD**:
  - led stays frozen.
  - seg_data = {bar tens, bar ones, U, P} if bar<target, else {bar tens, bar ones, d, n}.
  - The next rising edge returns to RUN, continuing from the frozen bar and direction. The tick counter is cleared.
- **WIN**: seg_data = {g,o,o,d}, win=1, led frozen. Sticky until active=0 or reset.
- **LOSE**: seg_data = {L,o,S,E}, lose=1, led=0. Sticky until active=0 or reset.
- Decimal split: values are ≤32, so tens = 0..3 and ones = value − 10·tens.

## Timing
- Reset (async on reset_n low) sets:
  - state=IDLE, led=0, seg_data=20'hFFFFF, win=0, lose=0;
  - tries_left=MAX_TRIES, bar=0, the tick counter and the edge register to 0;
  - LFSR=16'hACE1.
- All outputs are registered. The response to an edge sampled at cycle n appears at cycle n+1.
- Tick counter:
  - runs 0..TICK_CYCLES−1 only in RUN;
  - a step occurs on the cycle the counter equals TICK_CYCLES−1;
  - the counter is cleared on every entry to RUN.
- Edge: btn_go_stop & ~btn_prev, with btn_prev registered every cycle in all states. A held button produces exactly one edge.
- A button edge and a tick in the same RUN cycle: the edge wins, the step is suppressed, and the pre-tick bar is judged.
- Edges in IDLE, WIN and LOSE are ignored.
- active falling in any state takes the block to IDLE on the next clk, with outputs cleared as on reset except the LFSR.
- reset_n asserted mid-RUN or mid-HOLD takes effect immediately (async). Operation restarts from IDLE after release.

## Test plan
- **Reset:** NUM_LEDS=8, TICK_CYCLES=4; hold reset_n=0, then release with active=0 -> seg_data=20'hFFFFF, led=0, tries_left=8, win=lose=0.
- **Ping-pong:** NUM_LEDS=4, TICK_CYCLES=4, active=1, no presses -> led sequence 0001,0011,0111,1111,0111,0011,0001,0011 with each value held 4 cycles.
- **Hint:** read the target T from seg_data, press when bar=T−1 -> HOLD shows {tens(T−1), ones(T−1), U, P} and tries_left=7. Press when bar=T+1 -> {…, d, n}.
- **Win:** press when bar=T -> next cycle seg_data={9,17,17,19}, win=1. Further presses change nothing.
- **Lose:** MAX_TRIES=2, two misses -> after the second, seg_data={21,17,5,14}, lose=1, led=0, tries_left=0.
- **Simultaneous and abort:** press on the tick cycle with bar=3 -> bar 3 is judged, not 4. Then drop active in HOLD -> the next cycle is IDLE with outputs blank. Re-enabling yields a fresh target and tries_left=MAX_TRIES.
